// File: rtl/uart_rx_frame_buffer_if.sv
// Bus bundle between the UART Rx controller/datapath, the frame buffer and the host read port.
// The master side drives frame strobes and the read handshake; the slave side is the buffer.
interface uart_rx_frame_buffer_if #(
    parameter int data_size  = 8,
    parameter int addr_width = 3
);
    logic [data_size-1:0]  rx_data;
    logic                  data_err_en;
    logic                  data_error;
    logic                  trans_err_en;
    logic                  trans_error;
    logic                  frame_done_en;
    logic                  frame_done;
    logic                  rd_ready;
    logic                  ovf_clr;
    logic                  rd_valid;
    logic [data_size-1:0]  rd_data;
    logic                  rd_parity_err;
    logic                  rd_frame_err;
    logic [addr_width:0]   level;
    logic                  overflow;
    logic [7:0]            err_cnt;

    modport master (
        output rx_data, data_err_en, data_error, trans_err_en, trans_error,
               frame_done_en, frame_done, rd_ready, ovf_clr,
        input  rd_valid, rd_data, rd_parity_err, rd_frame_err, level, overflow, err_cnt
    );

    modport slave (
        input  rx_data, data_err_en, data_error, trans_err_en, trans_error,
               frame_done_en, frame_done, rd_ready, ovf_clr,
        output rd_valid, rd_data, rd_parity_err, rd_frame_err, level, overflow, err_cnt
    );
endinterface

// File: rtl/uart_rx_frame_buffer.sv
// Merges UART Rx per-frame status strobes with the received byte into tagged entries,
// buffers them in a show-ahead FIFO and tracks overflow and error statistics.
module uart_rx_frame_buffer #(
    parameter int data_size    = 8,
    parameter int addr_width   = 3,
    parameter bit drop_errored = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_rx_frame_buffer_if.slave   bus
);
    localparam int DEPTH = 2 ** addr_width;
    localparam int EW    = data_size + 2;

    // Entry layout: {frame_err, parity_err, data}
    function automatic logic f_entry_errored(input logic [EW-1:0] entry);
        return entry[EW-1] | entry[EW-2];
    endfunction

    logic [EW-1:0]       r_mem [DEPTH];
    logic [addr_width:0] r_wr_ptr;
    logic [addr_width:0] r_rd_ptr;
    logic [addr_width:0] r_level;
    logic                r_par_pend;
    logic                r_rd_valid;
    logic                r_overflow;
    logic [7:0]          r_err_cnt;
    logic [EW-1:0]       r_head;

    logic                w_commit;
    logic [EW-1:0]       w_entry;
    logic                w_errored;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_policy_drop;
    logic                w_write;
    logic                w_ovf_set;
    logic [addr_width:0] w_wr_ptr_nxt;
    logic [addr_width:0] w_rd_ptr_nxt;
    logic [addr_width:0] w_level_nxt;
    logic [EW-1:0]       w_head_nxt;

    // Commit decode, FIFO status and next-state of pointers and head entry
    always_comb begin
        w_commit      = bus.frame_done_en & bus.frame_done;
        w_entry       = {bus.trans_err_en & bus.trans_error, r_par_pend, bus.rx_data};
        w_errored     = f_entry_errored(w_entry);
        w_empty       = (r_wr_ptr == r_rd_ptr);
        w_full        = (r_wr_ptr[addr_width] != r_rd_ptr[addr_width]) &&
                        (r_wr_ptr[addr_width-1:0] == r_rd_ptr[addr_width-1:0]);
        w_pop         = ~w_empty & bus.rd_ready;
        w_policy_drop = drop_errored & w_errored;
        w_write       = w_commit & ~w_policy_drop & (~w_full | w_pop);
        w_ovf_set     = w_commit & ~w_policy_drop & w_full & ~w_pop;
        w_wr_ptr_nxt  = r_wr_ptr + {{addr_width{1'b0}}, w_write};
        w_rd_ptr_nxt  = r_rd_ptr + {{addr_width{1'b0}}, w_pop};
        w_level_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;
        // The slot about to become head may be the one being written this cycle
        w_head_nxt    = {EW{1'b0}};
        if (w_level_nxt == {(addr_width+1){1'b0}}) begin
            w_head_nxt = {EW{1'b0}};
        end else if (w_write && (w_rd_ptr_nxt[addr_width-1:0] == r_wr_ptr[addr_width-1:0])) begin
            w_head_nxt = w_entry;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt[addr_width-1:0]];
        end
    end

    // Entry storage; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[addr_width-1:0]] <= w_entry;
        end
    end

    // Pointers, registered read port, parity pending flag and status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= {(addr_width+1){1'b0}};
            r_rd_ptr   <= {(addr_width+1){1'b0}};
            r_level    <= {(addr_width+1){1'b0}};
            r_par_pend <= 1'b0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_head     <= {EW{1'b0}};
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_level    <= w_level_nxt;
            r_rd_valid <= (w_level_nxt != {(addr_width+1){1'b0}});
            r_head     <= w_head_nxt;
            // Any frame_done_en ends the frame, committed or aborted
            if (bus.frame_done_en) begin
                r_par_pend <= 1'b0;
            end else if (bus.data_err_en) begin
                r_par_pend <= bus.data_error;
            end else begin
                r_par_pend <= r_par_pend;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
            if (w_commit && w_errored && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = r_head[data_size-1:0];
    assign bus.rd_parity_err = r_head[EW-2];
    assign bus.rd_frame_err  = r_head[EW-1];
    assign bus.level         = r_level;
    assign bus.overflow      = r_overflow;
    assign bus.err_cnt       = r_err_cnt;
endmodule
